// File: rtl/dfe_pkg.sv
// dfe_pkg: shared types and rate defaults for the DFE sample scheduler.
//   dfe_state_e  - scheduler state (IDLE / FILL / RUN)
//   DFE_*        - default rate and settle parameters
//   frac_step()  - one step of the L/M modulo accumulator
package dfe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } dfe_state_e;

    localparam int unsigned DFE_IN_DIV     = 2;
    localparam int unsigned DFE_UP_L       = 2;
    localparam int unsigned DFE_DOWN_M     = 3;
    localparam int unsigned DFE_SETTLE_CNT = 64;

    typedef struct packed {
        logic       wrap;
        logic [3:0] acc;
    } frac_step_t;

    // acc + up_l, reduced modulo down_m; wrap flags that an output sample is due.
    // acc < down_m <= 15 and up_l < down_m, so the sum always fits in 5 bits.
    function automatic frac_step_t frac_step(input logic [3:0] acc,
                                             input logic [3:0] up_l,
                                             input logic [3:0] down_m);
        logic [4:0] sum_v;
        frac_step_t res_v;
        sum_v = {1'b0, acc} + {1'b0, up_l};
        if (sum_v >= {1'b0, down_m}) begin
            res_v.wrap = 1'b1;
            res_v.acc  = 4'(sum_v - {1'b0, down_m});
        end else begin
            res_v.wrap = 1'b0;
            res_v.acc  = sum_v[3:0];
        end
        return res_v;
    endfunction

endpackage

// File: rtl/dfe_frac_acc.sv
// dfe_frac_acc: modulo accumulator of the L/M fractional decimator.
//   clk, rst_n  - clock, async active-low reset
//   clr         - clear the accumulator (chain entry/exit)
//   adv         - advance by UP_L (one per input sample while filtering)
//   fd_strobe   - one-cycle pulse the cycle after an advance that wraps
//   fd_phase    - polyphase index of the latest fd_strobe, held in between
module dfe_frac_acc
    import dfe_pkg::*;
#(
    parameter int unsigned UP_L   = DFE_UP_L,
    parameter int unsigned DOWN_M = DFE_DOWN_M
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       adv,
    output logic       fd_strobe,
    output logic [3:0] fd_phase
);

    localparam logic [3:0] UP_L_C   = 4'(UP_L);
    localparam logic [3:0] DOWN_M_C = 4'(DOWN_M);

    logic [3:0] acc_r;
    logic       fd_strobe_r;
    logic [3:0] fd_phase_r;
    frac_step_t step_s;

    // Candidate next accumulator value and wrap flag.
    always_comb begin
        step_s = frac_step(acc_r, UP_L_C, DOWN_M_C);
    end

    // Accumulator, output strobe and held phase; clear wins over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= 4'd0;
            fd_strobe_r <= 1'b0;
            fd_phase_r  <= 4'd0;
        end else if (clr) begin
            acc_r       <= 4'd0;
            fd_strobe_r <= 1'b0;
        end else if (adv) begin
            acc_r       <= step_s.acc;
            fd_strobe_r <= step_s.wrap;
            if (step_s.wrap) begin
                fd_phase_r <= step_s.acc;
            end
        end else begin
            fd_strobe_r <= 1'b0;
        end
    end

    assign fd_strobe = fd_strobe_r;
    assign fd_phase  = fd_phase_r;

endmodule

// File: rtl/dfe_sched.sv
// dfe_sched: strobe scheduler for the DFE chain (input divider, L/M
// fractional decimator, notch, settle tracking and bypass control).
//   CLK, RST       - clock, async active-low reset
//   filter_enable  - 1 = filter chain, 0 = bypass (sampled on in_strobe)
//   in_strobe      - input sample enable, every IN_DIV cycles
//   fd_strobe      - decimator output enable, fd_phase its polyphase index
//   notch_strobe   - notch enable, one cycle after fd_strobe
//   flush          - one-cycle delay-line clear on chain entry
//   bypass         - data-path mux select (1 in IDLE)
//   out_valid      - data_out carries a valid sample
//   settled        - chain in steady state (RUN)
module dfe_sched
    import dfe_pkg::*;
#(
    parameter int unsigned IN_DIV     = DFE_IN_DIV,
    parameter int unsigned UP_L       = DFE_UP_L,
    parameter int unsigned DOWN_M     = DFE_DOWN_M,
    parameter int unsigned SETTLE_CNT = DFE_SETTLE_CNT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       filter_enable,
    output logic       in_strobe,
    output logic       fd_strobe,
    output logic [3:0] fd_phase,
    output logic       notch_strobe,
    output logic       flush,
    output logic       bypass,
    output logic       out_valid,
    output logic       settled
);

    localparam logic [7:0] DIV_LAST    = 8'(IN_DIV - 1);
    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CNT - 1);

    logic [7:0] div_cnt_r;
    logic [7:0] div_next_s;
    logic       in_strobe_r;
    dfe_state_e state_r;
    dfe_state_e state_next_s;
    logic       flush_s;
    logic       acc_clr_s;
    logic       acc_adv_s;
    logic       settle_inc_s;
    logic       settle_clr_s;
    logic [9:0] settle_cnt_r;
    logic       fd_strobe_s;
    logic [3:0] fd_phase_s;
    logic       notch_strobe_r;
    logic       in_d1_r;
    logic       out_valid_r;
    logic       bypass_r;
    logic       settled_r;

    // Next input-divider count, wrapping at IN_DIV-1.
    always_comb begin
        if (div_cnt_r == DIV_LAST) begin
            div_next_s = 8'd0;
        end else begin
            div_next_s = div_cnt_r + 8'd1;
        end
    end

    // Input divider; in_strobe is registered from the next count so it is
    // high exactly while div_cnt == IN_DIV-1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_cnt_r   <= 8'd0;
            in_strobe_r <= 1'b0;
        end else begin
            div_cnt_r   <= div_next_s;
            in_strobe_r <= (div_next_s == DIV_LAST);
        end
    end

    // Next-state and control decode; leaving the chain takes priority over
    // advancing the accumulator on the same in_strobe.
    always_comb begin
        state_next_s = state_r;
        flush_s      = 1'b0;
        acc_clr_s    = 1'b0;
        acc_adv_s    = 1'b0;
        settle_inc_s = 1'b0;
        settle_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_strobe_r && filter_enable) begin
                    state_next_s = ST_FILL;
                    flush_s      = 1'b1;
                    acc_clr_s    = 1'b1;
                    settle_clr_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (in_strobe_r && !filter_enable) begin
                    state_next_s = ST_IDLE;
                    acc_clr_s    = 1'b1;
                    settle_clr_s = 1'b1;
                end else begin
                    acc_adv_s    = in_strobe_r;
                    settle_inc_s = notch_strobe_r;
                    if (notch_strobe_r && (settle_cnt_r == SETTLE_LAST)) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end
            end
            ST_RUN: begin
                if (in_strobe_r && !filter_enable) begin
                    state_next_s = ST_IDLE;
                    acc_clr_s    = 1'b1;
                    settle_clr_s = 1'b1;
                end else begin
                    acc_adv_s = in_strobe_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                acc_clr_s    = 1'b1;
                settle_clr_s = 1'b1;
            end
        endcase
    end

    // State register with bypass/settled registered alongside it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= ST_IDLE;
            bypass_r  <= 1'b1;
            settled_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            bypass_r  <= (state_next_s == ST_IDLE);
            settled_r <= (state_next_s == ST_RUN);
        end
    end

    // Count notch samples seen while filling.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            settle_cnt_r <= 10'd0;
        end else if (settle_clr_s) begin
            settle_cnt_r <= 10'd0;
        end else if (settle_inc_s) begin
            settle_cnt_r <= settle_cnt_r + 10'd1;
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    dfe_frac_acc #(
        .UP_L   (UP_L),
        .DOWN_M (DOWN_M)
    ) u_frac_acc (
        .clk       (CLK),
        .rst_n     (RST),
        .clr       (acc_clr_s),
        .adv       (acc_adv_s),
        .fd_strobe (fd_strobe_s),
        .fd_phase  (fd_phase_s)
    );

    // Strobe delay line and out_valid. The gate is the state while the last
    // delay stage holds the strobe, so a strobe in flight across a state
    // change finishes, and the 64th notch (still in FILL) gives no out_valid.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            notch_strobe_r <= 1'b0;
            in_d1_r        <= 1'b0;
            out_valid_r    <= 1'b0;
        end else begin
            notch_strobe_r <= fd_strobe_s;
            in_d1_r        <= in_strobe_r;
            out_valid_r    <= ((state_r == ST_IDLE) && in_d1_r) ||
                              ((state_r == ST_RUN) && notch_strobe_r);
        end
    end

    assign in_strobe    = in_strobe_r;
    assign fd_strobe    = fd_strobe_s;
    assign fd_phase     = fd_phase_s;
    assign notch_strobe = notch_strobe_r;
    assign flush        = flush_s;
    assign bypass       = bypass_r;
    assign out_valid    = out_valid_r;
    assign settled      = settled_r;

endmodule

// File: tb/tb_dfe_sched.sv
// tb_dfe_sched: directed bench for dfe_sched (default rates) plus a second
// instance with IN_DIV=3, UP_L=1, DOWN_M=2.
module tb_dfe_sched;

    typedef struct packed {
        logic       in_s;
        logic       flush;
        logic       bypass;
        logic       fd;
        logic [3:0] phase;
        logic       notch;
        logic       ov;
        logic       settled;
    } vec_t;

    logic CLK_tb = 1'b0;
    always #5 CLK_tb = ~CLK_tb;

    logic       rst, fe;
    logic       in_strobe, fd_strobe, notch_strobe, flush, bypass, out_valid, settled;
    logic [3:0] fd_phase;

    logic       rst2, fe2;
    logic       in2, fd2, notch2, flush2, bypass2, ov2, settled2;
    logic [3:0] ph2;

    dfe_sched dut (
        .CLK (CLK_tb), .RST (rst), .filter_enable (fe),
        .in_strobe (in_strobe), .fd_strobe (fd_strobe), .fd_phase (fd_phase),
        .notch_strobe (notch_strobe), .flush (flush), .bypass (bypass),
        .out_valid (out_valid), .settled (settled)
    );

    dfe_sched #(.IN_DIV(3), .UP_L(1), .DOWN_M(2), .SETTLE_CNT(4)) dut2 (
        .CLK (CLK_tb), .RST (rst2), .filter_enable (fe2),
        .in_strobe (in2), .fd_strobe (fd2), .fd_phase (ph2),
        .notch_strobe (notch2), .flush (flush2), .bypass (bypass2),
        .out_valid (ov2), .settled (settled2)
    );

    int         n_pass = 0;
    int         n_total = 0;
    logic       prev_in, prev_in2, prev_fd, prev_notch;
    int         j;
    logic       exp_fd;
    logic [3:0] exp_ph;
    vec_t       vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t get_act();
        return '{in_strobe, flush, bypass, fd_strobe, fd_phase,
                 notch_strobe, out_valid, settled};
    endfunction

    task automatic check_vec(input string name, input vec_t exp);
        vec_t act;
        act = get_act();
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (in,flush,byp,fd,ph,notch,ov,set)",
                      name, act, exp);
    endtask

    task automatic step();
        prev_in2   = prev_in;
        prev_in    = in_strobe;
        prev_fd    = fd_strobe;
        prev_notch = notch_strobe;
        @(negedge CLK_tb);
    endtask

    // in_strobe index j while filtering: j%3==1 none, ==2 phase 1, ==0 phase 0
    task automatic track();
        if (in_strobe) begin
            j++;
            exp_fd = ((j % 3) != 1);
            exp_ph = ((j % 3) == 2) ? 4'd1 : 4'd0;
        end
    endtask

    initial begin
        int notch_cnt, ov_seen, ins, fd_cnt, last, cnt;
        logic pending;
        vec_t rv;

        // cycle after reset release, filter_enable=1
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        rv      = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

        prev_in = 1'b0; prev_in2 = 1'b0; prev_fd = 1'b0; prev_notch = 1'b0;
        exp_fd = 1'b0; exp_ph = 4'd0; j = 0;
        rst = 1'b0; fe = 1'b1; rst2 = 1'b0; fe2 = 1'b1;
        repeat (3) @(negedge CLK_tb);
        check_vec("reset_state", rv);
        rst = 1'b1; rst2 = 1'b1;

        // start-up: divider, single flush, first fd/notch pattern
        for (int i = 0; i < 10; i++) begin
            step();
            check_vec($sformatf("startup_c%0d", i + 1), vecs[i]);
        end

        // fill: 64 notches without out_valid, then settled
        j = 4; notch_cnt = 2; ov_seen = 0;
        for (int k = 0; k < 600; k++) begin
            step();
            track();
            if (settled) break;
            if (notch_strobe) notch_cnt++;
            if (out_valid) ov_seen++;
        end
        check("settled_rise", settled, 1);
        check("settle_notches", notch_cnt, 64);
        check("settled_lag", prev_notch, 1);
        check("ov_after_64th", out_valid, 0);
        check("fill_ov_zero", ov_seen, 0);
        check("run_bypass", bypass, 0);

        // run: 30 in_strobes -> 20 fd_strobes, phase pattern, out_valid lag
        pending = 1'b0; ins = 0; fd_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            check("run_ov", out_valid, prev_notch);
            if (pending) begin
                check("run_fd", fd_strobe, exp_fd);
                if (exp_fd) check("run_phase", fd_phase, exp_ph);
                if (fd_strobe) fd_cnt++;
                pending = 1'b0;
            end
            if (ins == 30) break;
            if (in_strobe) begin
                track();
                ins++;
                pending = 1'b1;
            end
        end
        check("run_in_count", ins, 30);
        check("run_fd_count", fd_cnt, 20);

        // drop filter_enable mid-RUN
        fe = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (in_strobe) break;
            step();
        end
        check("exit_in_strobe", in_strobe, 1);
        step();
        check("exit_bypass", bypass, 1);
        check("exit_settled", settled, 0);
        step(); step();
        for (int k = 0; k < 20; k++) begin
            step();
            check("idle_fd", fd_strobe, 0);
            check("idle_notch", notch_strobe, 0);
            check("idle_ov", out_valid, prev_in2);
        end

        // re-enter FILL, then async reset between edges
        fe = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (in_strobe) break;
            step();
        end
        check("reenter_flush", flush, 1);
        for (int k = 0; k < 20; k++) begin
            step();
            if (fd_phase == 4'd1) break;
        end
        check("fill_phase_seen", fd_phase, 1);
        #2;
        rst = 1'b0; fe = 1'b0;
        #1;
        check_vec("async_reset", rv);
        @(negedge CLK_tb);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            vec_t ev;
            step();
            ev = '{((k % 2) == 0), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0,
                   ((k >= 2) && ((k % 2) == 0)), 1'b0};
            check_vec($sformatf("post_reset_c%0d", k + 1), ev);
        end
        fe = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (in_strobe) break;
            step();
        end
        check("flush_after_reset", flush, 1);

        // second instance: IN_DIV=3, L=1, M=2
        last = -1; cnt = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (fd2) begin
                cnt++;
                check("fd2_phase", ph2, 0);
                if (last >= 0) check("fd2_gap", c - last, 6);
                last = c;
            end
        end
        check("fd2_count", cnt, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dfe_sched.md
DFE_SCHED -- requirements
Module: dfe_sched

Interface
REQ-001 SHALL have parameter IN_DIV, default 2, meaning clock cycles per input sample (18 MHz clock, 9 MHz input); legal range 2..255.
REQ-002 SHALL have parameter UP_L, default 2, meaning fractional-decimator interpolation factor; legal range 1 <= UP_L < DOWN_M.
REQ-003 SHALL have parameter DOWN_M, default 3, meaning fractional-decimator decimation factor; legal range up to 15.
REQ-004 SHALL have parameter SETTLE_CNT, default 64, meaning FD output samples suppressed after enable; legal range 1..1023.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port filter_enable, input, 1 bit: 1 selects the filter chain, 0 selects bypass.
REQ-008 SHALL have port in_strobe, output, 1 bit: input-sample enable for the decimator.
REQ-009 SHALL have port fd_strobe, output, 1 bit: decimator output-sample enable.
REQ-010 SHALL have port fd_phase, output, 4 bits: polyphase index for the current fd_strobe.
REQ-011 SHALL have port notch_strobe, output, 1 bit: notch-filter sample enable.
REQ-012 SHALL have port flush, output, 1 bit: one-cycle clear of filter delay lines.
REQ-013 SHALL have port bypass, output, 1 bit: data-path mux select.
REQ-014 SHALL have port out_valid, output, 1 bit: data_out carries a valid sample.
REQ-015 SHALL have port settled, output, 1 bit: the chain is in steady state.

Function
REQ-016 SHALL run div_cnt 0..IN_DIV-1, wrapping, in every state; in_strobe = (div_cnt == IN_DIV-1).
REQ-017 SHALL, on each in_strobe in FILL/RUN, compute acc + UP_L; if >= DOWN_M, store (sum - DOWN_M) and assert fd_strobe next cycle with fd_phase = stored value; else store sum, no fd_strobe.
REQ-018 SHALL hold fd_phase until the next fd_strobe; fd_strobe is at most one cycle per in_strobe.
REQ-019 SHALL assert notch_strobe exactly 1 cycle after each fd_strobe.
REQ-020 SHALL have states IDLE, FILL, RUN; filter_enable is sampled only on in_strobe cycles.
REQ-021 SHALL go IDLE->FILL on in_strobe with filter_enable=1; pulse flush that cycle; clear acc and settle counter.
REQ-022 SHALL go FILL->RUN on the notch_strobe that makes the settle count reach SETTLE_CNT.
REQ-023 SHALL go FILL or RUN -> IDLE on in_strobe with filter_enable=0; acc and settle counter clear.
REQ-024 SHALL, in IDLE: bypass=1, fd_strobe=notch_strobe=0, out_valid = in_strobe delayed 2 cycles.
REQ-025 SHALL, in FILL: bypass=0, out_valid=0.
REQ-026 SHALL, in RUN: out_valid = notch_strobe delayed 1 cycle; settled=1 only in RUN.
REQ-027 SHALL let strobes already in flight at a state change complete; out_valid gating uses the state at the delayed cycle.

Reset
REQ-028 SHALL, while RST=0 and asynchronously: state=IDLE, div_cnt=0, acc=0, settle counter=0, fd_phase=0, all strobe/valid delay registers 0, bypass=1, flush=0, settled=0.
REQ-029 SHALL, on RST deassertion mid-operation, restart from IDLE; no flush until the next IDLE->FILL.

Structure
REQ-030 SHALL put the state enum (IDLE/FILL/RUN) and the rate defaults (IN_DIV, UP_L, DOWN_M) in the shared dfe_pkg package.
REQ-031 SHALL use one sub-module, dfe_frac_acc, for the modulo accumulator and phase output; everything else inline.

Verification
REQ-032 SHALL check: reset released, filter_enable=1 -> in_strobe on every 2nd cycle; flush pulses once on the first in_strobe.
REQ-033 SHALL check: RUN, 30 in_strobes -> exactly 20 fd_strobes; pattern none, yes(phase 1), yes(phase 0) repeating.
REQ-034 SHALL check: SETTLE_CNT=64 -> out_valid stays 0 for the first 64 notch_strobes, settled rises with the 64th, and out_valid follows 1 cycle after each later notch_strobe.
REQ-035 SHALL check: filter_enable dropped mid-RUN -> IDLE at the next in_strobe; bypass=1; out_valid 2 cycles after each in_strobe; no fd_strobe.
REQ-036 SHALL check: RST=0 asserted between edges during FILL -> all outputs at reset values immediately; after release, no strobes other than in_strobe until filter_enable is seen.
REQ-037 SHALL check: IN_DIV=3, UP_L=1, DOWN_M=2 -> one fd_strobe per 6 cycles; fd_phase always 0.
